// File: rtl/divshare_pkg.sv
// Shared types and defaults for the divider share scheduler.
// Holds the scheduler state encoding, default widths and the ID-width helper.
package divshare_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    IDLE  = 2'd1,
    ISSUE = 2'd2,
    BUSY  = 2'd3
  } state_t;

  localparam int DEF_NREQ = 4;
  localparam int DEF_DW   = 20;
  localparam int DEF_VW   = 4;

  // Width needed to hold a requester index; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/divider_share_scheduler_rr_pick.sv
// Combinational round-robin picker.
// Grants the first asserted request at or after the pointer, wrapping modulo NREQ.
module rr_pick
  import divshare_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic [IW-1:0] w_cand;

  // Walk the requesters starting at the pointer and stop at the first hit.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = IW'((int'(i_ptr) + k) % NREQ);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/divider_share_scheduler.sv
// Round-robin scheduler sharing one sequential divider among NREQ requesters.
// Optional macro DIVSHARE_ZERO_BYPASS_EN answers divisor-0 requests locally
// (quotient 0, rsp_dbz pulse) without starting the divider.
module divider_share_scheduler
  import divshare_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int DW   = DEF_DW,
  parameter int VW   = DEF_VW
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [NREQ-1:0]    i_req_valid,
  input  logic [NREQ*DW-1:0] i_req_dividend,
  input  logic [NREQ*VW-1:0] i_req_divisor,
  output logic [NREQ-1:0]    o_req_ready,
  output logic [NREQ-1:0]    o_rsp_valid,
  output logic [DW-1:0]      o_rsp_result,
`ifdef DIVSHARE_ZERO_BYPASS_EN
  output logic             o_rsp_dbz,
`endif
  output logic             o_div_start,
  output logic [DW-1:0]    o_div_dividend,
  output logic [VW-1:0]    o_div_divisor,
  input  logic [DW-1:0]    i_div_result,
  input  logic             i_div_result_ready
);

  localparam int IW = clog2(NREQ);

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_curId;
  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic [IW-1:0]   w_ptrNext;
  logic [NREQ-1:0] w_rspOneHot;
  logic [DW-1:0]   w_selDividend;
  logic [VW-1:0]   w_selDivisor;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Operand mux for the requester the picker selected.
  always_comb begin
    w_selDividend = '0;
    w_selDivisor  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_idx == IW'(i)) begin
        w_selDividend = i_req_dividend[i*DW +: DW];
        w_selDivisor  = i_req_divisor[i*VW +: VW];
      end
    end
  end

  // The accept pulse is only offered while idle so the requester sees it in the accept cycle.
  assign o_req_ready = (r_state == IDLE) ? w_grant : '0;
  assign w_ptrNext   = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);
  assign w_rspOneHot = {{(NREQ-1){1'b0}}, 1'b1} << r_curId;

  // Scheduler FSM: sync to the unreset divider, accept, start, wait, respond.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= SYNC;
      r_ptr          <= '0;
      r_curId        <= '0;
      o_rsp_valid    <= '0;
      o_rsp_result   <= '0;
      o_div_start    <= 1'b0;
      o_div_dividend <= '0;
      o_div_divisor  <= '0;
`ifdef DIVSHARE_ZERO_BYPASS_EN
      o_rsp_dbz      <= 1'b0;
`endif
    end else begin
      o_div_start <= 1'b0;
      o_rsp_valid <= '0;
`ifdef DIVSHARE_ZERO_BYPASS_EN
      o_rsp_dbz   <= 1'b0;
`endif
      case (r_state)
        SYNC: begin
          if (i_div_result_ready) r_state <= IDLE;
        end
        IDLE: begin
          if (w_any) begin
            o_div_dividend <= w_selDividend;
            o_div_divisor  <= w_selDivisor;
            r_curId        <= w_idx;
            r_ptr          <= w_ptrNext;
`ifdef DIVSHARE_ZERO_BYPASS_EN
            if (w_selDivisor == '0) begin
              o_rsp_valid  <= w_grant;
              o_rsp_result <= '0;
              o_rsp_dbz    <= 1'b1;
            end else begin
              o_div_start <= 1'b1;
              r_state     <= ISSUE;
            end
`else
            o_div_start <= 1'b1;
            r_state     <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          r_state <= BUSY;
        end
        BUSY: begin
          if (i_div_result_ready) begin
            o_rsp_result <= i_div_result;
            o_rsp_valid  <= w_rspOneHot;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state <= SYNC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_share_scheduler.sv
// Directed bench for divider_share_scheduler with a behavioural divider model.
// Honours DIVSHARE_ZERO_BYPASS_EN the same way the design does.
module tb_divider_share_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 20;
  localparam int VW   = 4;

  logic               clk = 1'b0;
  logic               rstN;
  logic [NREQ-1:0]    reqValid;
  logic [NREQ*DW-1:0] reqDividend;
  logic [NREQ*VW-1:0] reqDivisor;
  logic [NREQ-1:0]    reqReady;
  logic [NREQ-1:0]    rspValid;
  logic [DW-1:0]      rspResult;
  logic               divStart;
  logic [DW-1:0]      divDividend;
  logic [VW-1:0]      divDivisor;
  logic [DW-1:0]      divResult;
  logic               divResultReady;
`ifdef DIVSHARE_ZERO_BYPASS_EN
  logic               rspDbz;
`endif

  int checks = 0;
  int errors = 0;

  divider_share_scheduler #(.NREQ(NREQ), .DW(DW), .VW(VW)) dut (
    .i_clk              (clk),
    .i_rst_n            (rstN),
    .i_req_valid        (reqValid),
    .i_req_dividend     (reqDividend),
    .i_req_divisor      (reqDivisor),
    .o_req_ready        (reqReady),
    .o_rsp_valid        (rspValid),
    .o_rsp_result       (rspResult),
`ifdef DIVSHARE_ZERO_BYPASS_EN
    .o_rsp_dbz          (rspDbz),
`endif
    .o_div_start        (divStart),
    .o_div_dividend     (divDividend),
    .o_div_divisor      (divDivisor),
    .i_div_result       (divResult),
    .i_div_result_ready (divResultReady)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Divider model with no reset: busy 10 cycles at power-up, 10 per division, 3 for divisor 0.
  int          mdlCnt = 10;
  logic        mdlReady = 1'b0;
  logic [DW-1:0] mdlRes = '0;
  always @(posedge clk) begin
    if (divStart) begin
      mdlCnt   <= (divDivisor == '0) ? 3 : 10;
      mdlReady <= 1'b0;
      mdlRes   <= (divDivisor == '0) ? '0 : divDividend / {{(DW-VW){1'b0}}, divDivisor};
    end else if (mdlCnt > 0) begin
      mdlCnt <= mdlCnt - 1;
      if (mdlCnt == 1) mdlReady <= 1'b1;
    end
  end
  assign divResult      = mdlRes;
  assign divResultReady = mdlReady;

  // Index of the set bit in a one-hot vector, -1 if none.
  function automatic int oneHotIdx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Event log taken mid-cycle: grants, starts, responses and one-hot violations.
  int            grantQ[$];
  int            rspIdQ[$];
  logic [DW-1:0] rspResQ[$];
  int            startCnt = 0;
  int            oneHotErr = 0;
  always @(negedge clk) begin
    if (reqReady != '0) begin
      grantQ.push_back(oneHotIdx(reqReady));
      if ($countones(reqReady) != 1) oneHotErr++;
    end
    if (rspValid != '0) begin
      rspIdQ.push_back(oneHotIdx(rspValid));
      rspResQ.push_back(rspResult);
      if ($countones(rspValid) != 1) oneHotErr++;
    end
    if (divStart) startCnt++;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input int idx, input logic v, input logic [DW-1:0] dvd,
                               input logic [VW-1:0] dvs);
    reqValid[idx]              = v;
    reqDividend[idx*DW +: DW]  = dvd;
    reqDivisor[idx*VW +: VW]   = dvs;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic waitReady(input int bound, output int idx);
    idx = -1;
    for (int c = 0; c < bound; c++) begin
      if (reqReady != '0) begin
        idx = oneHotIdx(reqReady);
        break;
      end
      step();
    end
  endtask

  task automatic waitRsp(input int bound, output bit found);
    found = 1'b0;
    for (int c = 0; c < bound; c++) begin
      step();
      if (rspValid != '0) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitAfterSync(input int bound, output int readyCyc, output int acceptCyc);
    readyCyc  = -1;
    acceptCyc = -1;
    for (int c = 0; c < bound; c++) begin
      step();
      if (divResultReady && readyCyc < 0) readyCyc = c;
      if (reqReady != '0) begin
        acceptCyc = c;
        break;
      end
    end
  endtask

  int  idx, readyCyc, acceptCyc, sBase, gBase, rBase, nRsp;
  bit  found, stable;

  initial begin
    rstN        = 1'b1;
    reqValid    = '0;
    reqDividend = '0;
    reqDivisor  = '0;
    #1 rstN = 1'b0;
    applyStimulus(1, 1'b1, 20'd1000, 4'd10);
    #1;
    checkOutput("rst_req_ready", 32'(reqReady), 0);
    checkOutput("rst_rsp_valid", 32'(rspValid), 0);
    checkOutput("rst_rsp_result", 32'(rspResult), 0);
    checkOutput("rst_div_start", 32'(divStart), 0);
    checkOutput("rst_div_dividend", 32'(divDividend), 0);
    checkOutput("rst_div_divisor", 32'(divDivisor), 0);
    step();
    step();
    rstN = 1'b1;

    $display("[TB] power-up sync then 1000/10 from requester 1");
    waitAfterSync(60, readyCyc, acceptCyc);
    checkOutput("sync_ready_seen", 32'(readyCyc >= 0), 1);
    checkOutput("sync_accept_delay", 32'(acceptCyc - readyCyc), 1);
    checkOutput("t2_grant", 32'(reqReady), 32'b0010);
    sBase = startCnt;
    step();
    checkOutput("t2_start", 32'(divStart), 1);
    checkOutput("t2_dividend", 32'(divDividend), 1000);
    checkOutput("t2_divisor", 32'(divDivisor), 10);
    applyStimulus(1, 1'b0, 20'd5, 4'd3);
    stable = 1'b1;
    found  = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (rspValid != '0) begin
        found = 1'b1;
        break;
      end
      if (divDividend !== 20'd1000 || divDivisor !== 4'd10) stable = 1'b0;
    end
    checkOutput("t2_rsp_found", 32'(found), 1);
    checkOutput("t2_operands_stable", 32'(stable), 1);
    checkOutput("t2_rsp_valid", 32'(rspValid), 32'b0010);
    checkOutput("t2_rsp_result", 32'(rspResult), 100);
    step();
    checkOutput("t2_start_count", 32'(startCnt - sBase), 1);

    $display("[TB] all four requesters 1048575/15 continuously");
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b1, 20'd1048575, 4'd15);
    gBase = grantQ.size();
    rBase = rspIdQ.size();
    sBase = startCnt;
    nRsp  = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      if (rspValid != '0) nRsp++;
      if (nRsp >= 5) break;
    end
    reqValid = '0;
    step();
    step();
    checkOutput("t3_rsp_count", 32'(rspIdQ.size() - rBase), 5);
    checkOutput("t3_grant_count", 32'(grantQ.size() - gBase), 5);
    checkOutput("t3_start_count", 32'(startCnt - sBase), 5);
    for (int k = 0; k < 5; k++) begin
      if (gBase + k < grantQ.size()) checkOutput("t3_grant_order", 32'(grantQ[gBase+k]), 32'(k % 4));
      if (rBase + k < rspIdQ.size()) begin
        checkOutput("t3_rsp_id", 32'(rspIdQ[rBase+k]), 32'(k % 4));
        checkOutput("t3_rsp_result", 32'(rspResQ[rBase+k]), 69905);
      end
    end

    $display("[TB] back-to-back 1000/10 then 7/9");
    applyStimulus(1, 1'b1, 20'd1000, 4'd10);
    applyStimulus(3, 1'b1, 20'd7, 4'd9);
    #1;
    waitReady(20, idx);
    checkOutput("t4_first_grant", 32'(idx), 1);
    step();
    applyStimulus(1, 1'b0, 20'd0, 4'd0);
    waitRsp(60, found);
    checkOutput("t4_rsp1_valid", 32'(rspValid), 32'b0010);
    checkOutput("t4_rsp1_result", 32'(rspResult), 100);
    checkOutput("t4_b2b_accept", 32'(reqReady), 32'b1000);
    step();
    applyStimulus(3, 1'b0, 20'd0, 4'd0);
    checkOutput("t4_start2", 32'(divStart), 1);
    checkOutput("t4_dividend2", 32'(divDividend), 7);
    waitRsp(60, found);
    checkOutput("t4_rsp2_valid", 32'(rspValid), 32'b1000);
    checkOutput("t4_rsp2_result", 32'(rspResult), 0);

    $display("[TB] reset in the middle of a division");
    applyStimulus(2, 1'b1, 20'd1048575, 4'd15);
    #1;
    waitReady(20, idx);
    checkOutput("t5_grant", 32'(idx), 2);
    step();
    applyStimulus(2, 1'b0, 20'd0, 4'd0);
    step();
    step();
    rstN = 1'b0;
    #1;
    checkOutput("t5_rst_div_start", 32'(divStart), 0);
    checkOutput("t5_rst_dividend", 32'(divDividend), 0);
    checkOutput("t5_rst_divisor", 32'(divDivisor), 0);
    checkOutput("t5_rst_rsp_valid", 32'(rspValid), 0);
    checkOutput("t5_rst_req_ready", 32'(reqReady), 0);
    rBase = rspIdQ.size();
    applyStimulus(0, 1'b1, 20'd1000, 4'd10);
    step();
    rstN = 1'b1;
    waitAfterSync(60, readyCyc, acceptCyc);
    checkOutput("t5_sync_waited", 32'(readyCyc > 0), 1);
    checkOutput("t5_accept_delay", 32'(acceptCyc - readyCyc), 1);
    checkOutput("t5_grant_after", 32'(reqReady), 32'b0001);
    step();
    applyStimulus(0, 1'b0, 20'd0, 4'd0);
    waitRsp(60, found);
    checkOutput("t5_rsp_valid", 32'(rspValid), 32'b0001);
    checkOutput("t5_rsp_result", 32'(rspResult), 100);
    step();
    checkOutput("t5_no_stale_rsp", 32'(rspIdQ.size() - rBase), 1);

    $display("[TB] divisor 0 from requester 2");
    applyStimulus(2, 1'b1, 20'd1234, 4'd0);
    #1;
    waitReady(20, idx);
    checkOutput("t6_grant", 32'(idx), 2);
    sBase = startCnt;
    step();
    applyStimulus(2, 1'b0, 20'd0, 4'd0);
`ifdef DIVSHARE_ZERO_BYPASS_EN
    checkOutput("t6_rsp_valid", 32'(rspValid), 32'b0100);
    checkOutput("t6_rsp_dbz", 32'(rspDbz), 1);
    checkOutput("t6_rsp_result", 32'(rspResult), 0);
    checkOutput("t6_no_start", 32'(divStart), 0);
    step();
    checkOutput("t6_dbz_pulse", 32'(rspDbz), 0);
    checkOutput("t6_start_count", 32'(startCnt - sBase), 0);
`else
    checkOutput("t6_start", 32'(divStart), 1);
    checkOutput("t6_divisor", 32'(divDivisor), 0);
    waitRsp(30, found);
    checkOutput("t6_rsp_valid", 32'(rspValid), 32'b0100);
    checkOutput("t6_rsp_result", 32'(rspResult), 0);
    step();
    checkOutput("t6_start_count", 32'(startCnt - sBase), 1);
`endif

    step();
    checkOutput("onehot_violations", 32'(oneHotErr), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_share_scheduler.md
# divider_share_scheduler

Round-robin scheduler sharing one sequential 20/4-bit MSB-normalised quotient divider among NREQ requesters. It accepts one request at a time and holds the operands stable for the whole division. It sequences the divider's start/result_ready protocol and returns each quotient to its requester as a one-cycle response pulse. It sits between the GCD/test datapath clients and a single divider instance.

## Interface
- NREQ, 4: number of requesters (2..8)
- DW, 20: dividend/quotient width
- VW, 4: divisor width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  NREQ  request pending per requester; held with operands until accepted
- req_dividend  in  NREQ*DW  dividends, requester i at [i*DW +: DW]
- req_divisor  in  NREQ*VW  divisors, requester i at [i*VW +: VW]
- req_ready  out  NREQ  one-hot accept pulse; reset 0
- rsp_valid  out  NREQ  one-hot response pulse; reset 0
- rsp_result  out  DW  quotient, valid with rsp_valid; reset 0
- div_start  out  1  divider start pulse; reset 0
- div_dividend  out  DW  latched dividend to divider; reset 0
- div_divisor  out  VW  latched divisor to divider; reset 0
- div_result  in  DW  divider quotient
- div_result_ready  in  1  divider idle / result valid

## Operation
- States: SYNC, IDLE, ISSUE, BUSY. Reset enters SYNC.
- SYNC: the divider has no reset. Wait until div_result_ready=1, then go to IDLE. No accepts in SYNC.
- IDLE: pick the first asserted req_valid at or after pointer ptr (wrapping modulo NREQ). Pulse req_ready[g]. Latch operands into div_dividend/div_divisor and g into cur_id. Set ptr <= g+1 mod NREQ. Go to ISSUE.
- No request in IDLE: stay in IDLE; ptr is unchanged.
- ISSUE: div_start=1 for exactly one cycle, then go to BUSY.
- BUSY: div_start=0. When div_result_ready=1, register rsp_result <= div_result, pulse rsp_valid[cur_id], and go to IDLE.
- div_dividend/div_divisor are held constant from accept until leaving BUSY.
- Divisor contract: nonzero divisors must have bit VW-1 set; otherwise the quotient is undefined and passed through unchecked. Divisor 0 yields quotient 0.
- req_valid deasserting before accept is legal: that requester is simply not chosen. Requests are never dropped once accepted.
- Reset mid-division: return to SYNC. The stale divider result is discarded; SYNC waits for the divider to finish before any new issue.

## Timing
- Accept in cycle A. div_start high in A+1. BUSY from A+2.
- Divider drops result_ready the cycle of start and keeps it low through its init cycle, so BUSY may sample it from A+2 onward.
- Divider latency is up to 37 cycles after start, or 3 cycles for divisor 0. The scheduler must not depend on any fixed latency.
- rsp_valid is asserted in the cycle after result_ready is seen in BUSY. That cycle is IDLE, so a new accept may occur in the same cycle (back-to-back throughput).
- At most one request is outstanding; req_ready and rsp_valid are each at most one-hot.
- After reset, the first accept occurs no earlier than one cycle after div_result_ready is seen high.

## Configuration
- DIVSHARE_ZERO_BYPASS_EN defined:
  - A divisor-0 request accepted in IDLE skips ISSUE/BUSY.
  - rsp_valid[g] pulses the next cycle with rsp_result=0, and the divider is not started.
  - An extra output rsp_dbz (1 bit, reset 0) pulses with rsp_valid for bypassed requests.
- Undefined: divisor 0 is issued to the divider like any other request, and no rsp_dbz port exists.

## Structure
- Package divshare_pkg holds the state enum (SYNC/IDLE/ISSUE/BUSY), default NREQ/DW/VW, and the ID width function clog2(NREQ).
- Sub-module rr_pick: combinational round-robin picker. Inputs: request vector and ptr. Outputs: one-hot grant, index, any.
- Top level holds the FSM, operand/result registers, ptr and cur_id.

## Test plan
- After reset, divider model holds result_ready=0 for 10 cycles -> no req_ready until 1 cycle after it rises.
- Requester 1: 1000/10 -> req_ready[1] pulse, one div_start, rsp_valid[1] with rsp_result=100. Operands stable throughout BUSY.
- All 4 requesters valid continuously with 1048575/15 -> grants 0,1,2,3,0 in order; each rsp_result=69905; exactly one div_start per grant.
- 7/9 issued back-to-back after 1000/10 -> second accept coincides with the first rsp_valid; result 0.
- rst_n pulsed low mid-BUSY -> all outputs 0 asynchronously; no rsp_valid for the aborted request; SYNC waits for the divider to go idle.
- Divisor 0 from requester 2 -> rsp_result=0. With DIVSHARE_ZERO_BYPASS_EN: no div_start and rsp_dbz=1 in the cycle after accept.
